// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, FSM states and the byte-lane helper
// for the register-file memory responder.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int unsigned WCNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } ahb_state_e;

    // Little-endian lane mask; assumes the access has already been checked for alignment.
    function automatic logic [3:0] byte_en(input logic [1:0] lo, input logic [2:0] size);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << lo;
            HSIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite bus bundle between a master/decoder and one responder.
interface ahb_slave_mem_if;

    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic        hready;
    logic [31:0] hwdata;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hready, hwdata,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hready, hwdata,
        output hreadyout, hresp, hrdata
    );

endinterface

// File: rtl/ahb_slave_regfile.sv
// DEPTH x 32-bit flop array with async clear, byte-enable write port
// and one combinational read port.
module ahb_slave_regfile #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] widx_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] ridx_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite register-file memory responder: address/data phase tracking,
// programmable wait states, ERROR on illegal accesses, write-to-read forwarding.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic           hclk,
    input  logic           hreset,
    ahb_slave_mem_if.slave bus
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned OW   = AW + 2;
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);
    localparam logic [WCNT_W-1:0] WS_LAST =
        (WAIT_STATES > 0) ? WCNT_W'(WAIT_STATES - 1) : '0;

    ahb_state_e        state_q, state_d;
    logic [WCNT_W-1:0] cnt_q, cnt_d;
    logic [OW-1:0]     off_q, off_d;
    logic              write_q, write_d;
    logic [2:0]        size_q, size_d;
    logic [31:0]       hrdata_q, hrdata_d;

    logic [31:0]   bus_off;
    logic          accept;
    logic          legal;
    logic          ready_c;
    logic          resp_c;
    logic          load_rd;
    logic          rd_from_bus;
    logic          wr_en;
    logic [3:0]    wr_be;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [31:0]   mem_rdata;
    logic [31:0]   fwd_rdata;
    logic          unused_bits;

    // Unsigned subtraction makes addresses below BASE_ADDR wrap to huge offsets, so they fail the span check.
    function automatic logic addr_legal(input logic [31:0] off, input logic [2:0] size);
        logic ok;
        ok = (off < SPAN);
        case (size)
            HSIZE_BYTE: ok = ok;
            HSIZE_HALF: ok = ok & ~off[0];
            HSIZE_WORD: ok = ok & (off[1:0] == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign bus_off     = bus.haddr - BASE_ADDR;
    assign accept      = bus.hsel & bus.hready & bus.htrans[1];
    assign legal       = addr_legal(bus_off, bus.hsize);
    assign unused_bits = ^{bus.htrans[0], bus.hburst, bus.hprot, bus.hmastlock};

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            off_q    <= '0;
            write_q  <= 1'b0;
            size_q   <= HSIZE_BYTE;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            off_q    <= off_d;
            write_q  <= write_d;
            size_q   <= size_d;
            hrdata_q <= hrdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        write_d     = write_q;
        size_d      = size_q;
        ready_c     = 1'b1;
        resp_c      = HRESP_OKAY;
        load_rd     = 1'b0;
        rd_from_bus = 1'b0;

        case (state_q)
            ST_WAIT: begin
                ready_c = 1'b0;
                if (cnt_q == WS_LAST) begin
                    state_d = ST_DATA;
                    load_rd = ~write_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ERR1: begin
                ready_c = 1'b0;
                resp_c  = HRESP_ERROR;
                state_d = ST_ERR2;
            end
            ST_ERR2: resp_c = HRESP_ERROR;
            default: ;
        endcase

        // IDLE, DATA and ERR2 all end this cycle, so each may take the next address phase.
        if (ready_c) begin
            state_d = ST_IDLE;
            if (accept) begin
                off_d   = bus_off[OW-1:0];
                write_d = bus.hwrite;
                size_d  = bus.hsize;
                if (!legal) begin
                    state_d = ST_ERR1;
                end else if (WAIT_STATES > 0) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else begin
                    state_d     = ST_DATA;
                    load_rd     = ~bus.hwrite;
                    rd_from_bus = 1'b1;
                end
            end
        end
    end

    assign wr_en  = (state_q == ST_DATA) && write_q;
    assign wr_be  = byte_en(off_q[1:0], size_q);
    assign wr_idx = off_q[OW-1:2];
    assign rd_idx = rd_from_bus ? bus_off[OW-1:2] : off_q[OW-1:2];

    ahb_slave_regfile #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clk     (hclk),
        .rst     (hreset),
        .we_i    (wr_en),
        .be_i    (wr_be),
        .widx_i  (wr_idx),
        .wdata_i (bus.hwdata),
        .ridx_i  (rd_idx),
        .rdata_o (mem_rdata)
    );

    // A write retiring on the same edge as a read of that word supplies its new lanes directly.
    always_comb begin
        fwd_rdata = mem_rdata;
        for (int b = 0; b < 4; b++) begin
            if (wr_en && wr_be[b] && (wr_idx == rd_idx)) begin
                fwd_rdata[8*b +: 8] = bus.hwdata[8*b +: 8];
            end
        end
    end

    assign hrdata_d      = load_rd ? fwd_rdata : hrdata_q;
    assign bus.hreadyout = ready_c;
    assign bus.hresp     = resp_c;
    assign bus.hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: three instances (0, 2 and 3 wait states) on a shared
// bus, a vector table run through a scoreboard, plus pipelining and reset sequences.
module tb_ahb_slave_mem;
    import ahb_pkg::*;

    localparam int NDUT = 3;
    localparam int WS [NDUT] = '{0, 2, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NDUT-1:0]       rst;
    logic [NDUT-1:0]       hsel;
    logic [NDUT-1:0]       rdy;
    logic [NDUT-1:0]       rsp;
    logic [NDUT-1:0][31:0] rdat;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic        hwrite, hmastlock, hready;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        ahb_slave_mem_if bus ();
        assign bus.hsel      = hsel[g];
        assign bus.haddr     = haddr;
        assign bus.htrans    = htrans;
        assign bus.hwrite    = hwrite;
        assign bus.hsize     = hsize;
        assign bus.hburst    = hburst;
        assign bus.hprot     = hprot;
        assign bus.hmastlock = hmastlock;
        assign bus.hready    = hready;
        assign bus.hwdata    = hwdata;
        ahb_slave_mem #(
            .DEPTH       (16),
            .WAIT_STATES (WS[g]),
            .BASE_ADDR   (32'h0000_0000)
        ) u_dut (
            .hclk   (clk),
            .hreset (rst[g]),
            .bus    (bus)
        );
        assign rdy[g]  = bus.hreadyout;
        assign rsp[g]  = bus.hresp;
        assign rdat[g] = bus.hrdata;
    end

    typedef struct {
        string       name;
        int          dut;
        logic [1:0]  trans;
        logic        sel;
        logic        rdy;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  sz;
        logic [31:0] wd;
        logic        err;
        logic        chk_rd;
        logic [31:0] rd;
    } vec_t;

    typedef struct {
        string       name;
        logic        resp;
        logic        errw;
        int          waits;
        logic        chk_rd;
        logic [31:0] rd;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cur   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input string nm, input int d, input logic [1:0] tr,
                                input logic s, input logic r, input logic w,
                                input logic [31:0] a, input logic [2:0] z, input logic [31:0] wd,
                                input logic e, input logic c, input logic [31:0] rd);
        vecs.push_back('{nm, d, tr, s, r, w, a, z, wd, e, c, rd});
    endfunction

    // One isolated transfer: address phase, then data phase until hreadyout, then its closing edge.
    task automatic xfer(input logic [1:0] tr, input logic s, input logic r, input logic w,
                        input logic [31:0] a, input logic [2:0] z, input logic [31:0] wd,
                        output logic resp_o, output logic errw_o, output int waits_o,
                        output logic [31:0] rd_o);
        hsel   = s ? (NDUT'(1) << cur) : '0;
        htrans = tr;
        hready = r;
        hwrite = w;
        haddr  = a;
        hsize  = z;
        cyc();
        hsel    = '0;
        htrans  = HTRANS_IDLE;
        hready  = 1'b1;
        hwdata  = wd;
        waits_o = 0;
        errw_o  = 1'b0;
        @(negedge clk);
        while (!rdy[cur] && waits_o < 20) begin
            waits_o++;
            errw_o = errw_o | rsp[cur];
            cyc();
            @(negedge clk);
        end
        resp_o = rsp[cur];
        rd_o   = rdat[cur];
        cyc();
    endtask

    task automatic run_vecs();
        vec_t        v;
        exp_t        e;
        logic        acc, resp, errw;
        int          waits;
        logic [31:0] rd;
        while (vecs.size() > 0) begin
            v   = vecs.pop_front();
            acc = v.sel && v.rdy && v.trans[1];
            cur = v.dut;
            sb.push_back('{v.name, v.err, v.err, v.err ? 1 : (acc ? WS[v.dut] : 0), v.chk_rd, v.rd});
            xfer(v.trans, v.sel, v.rdy, v.wr, v.addr, v.sz, v.wd, resp, errw, waits, rd);
            e = sb.pop_front();
            chk({e.name, " hresp"}, 32'(resp), 32'(e.resp));
            chk({e.name, " err1"}, 32'(errw), 32'(e.errw));
            chk({e.name, " waits"}, 32'(waits), 32'(e.waits));
            if (e.chk_rd) chk({e.name, " hrdata"}, rd, e.rd);
        end
    endtask

    initial begin
        rst       = '1;
        hsel      = '0;
        haddr     = '0;
        htrans    = HTRANS_IDLE;
        hwrite    = 1'b0;
        hsize     = HSIZE_WORD;
        hburst    = 3'b000;
        hprot     = 4'b0011;
        hmastlock = 1'b0;
        hready    = 1'b1;
        hwdata    = '0;

        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("reset%0d hreadyout", d), 32'(rdy[d]), 32'd1);
            chk($sformatf("reset%0d hresp", d), 32'(rsp[d]), 32'd0);
            chk($sformatf("reset%0d hrdata", d), rdat[d], 32'd0);
        end
        cyc();
        rst = '0;
        cyc();

        // name, dut, trans, sel, rdy, wr, addr, size, wdata, err, chk_rd, rd
        add("w4_word",   0, HTRANS_NONSEQ, 1, 1, 1, 32'h4, HSIZE_WORD, 32'h1122_3344, 0, 0, 0);
        add("r4_word",   0, HTRANS_NONSEQ, 1, 1, 0, 32'h4, HSIZE_WORD, 0, 0, 1, 32'h1122_3344);
        add("w5_byte",   0, HTRANS_NONSEQ, 1, 1, 1, 32'h5, HSIZE_BYTE, 32'h0000_AA00, 0, 0, 0);
        add("r4_byte",   0, HTRANS_NONSEQ, 1, 1, 0, 32'h4, HSIZE_WORD, 0, 0, 1, 32'h1122_AA44);
        add("w6_half",   0, HTRANS_NONSEQ, 1, 1, 1, 32'h6, HSIZE_HALF, 32'h5566_0000, 0, 0, 0);
        add("r4_half",   0, HTRANS_NONSEQ, 1, 1, 0, 32'h4, HSIZE_WORD, 0, 0, 1, 32'h5566_AA44);
        add("r2_misal",  0, HTRANS_NONSEQ, 1, 1, 0, 32'h2, HSIZE_WORD, 0, 1, 1, 32'h5566_AA44);
        add("r40_range", 0, HTRANS_NONSEQ, 1, 1, 0, 32'h40, HSIZE_WORD, 0, 1, 1, 32'h5566_AA44);
        add("w40_range", 0, HTRANS_NONSEQ, 1, 1, 1, 32'h40, HSIZE_WORD, 32'hBAD0_BAD0, 1, 0, 0);
        add("w8_size3",  0, HTRANS_NONSEQ, 1, 1, 1, 32'h8, 3'b011, 32'hFFFF_FFFF, 1, 0, 0);
        add("w8_nosel",  0, HTRANS_NONSEQ, 0, 1, 1, 32'h8, HSIZE_WORD, 32'hCAFE_F00D, 0, 1, 32'h5566_AA44);
        add("w8_nordy",  0, HTRANS_NONSEQ, 1, 0, 1, 32'h8, HSIZE_WORD, 32'hCAFE_F00D, 0, 1, 32'h5566_AA44);
        add("w8_idle",   0, HTRANS_IDLE,   1, 1, 1, 32'h8, HSIZE_WORD, 32'h0F0F_0F0F, 0, 0, 0);
        add("wd_halfmis",0, HTRANS_NONSEQ, 1, 1, 1, 32'hD, HSIZE_HALF, 32'h1234_0000, 1, 0, 0);
        add("r8_clean",  0, HTRANS_NONSEQ, 1, 1, 0, 32'h8, HSIZE_WORD, 0, 0, 1, 32'h0);
        add("rc_clean",  0, HTRANS_NONSEQ, 1, 1, 0, 32'hC, HSIZE_WORD, 0, 0, 1, 32'h0);
        add("r0_noalias",0, HTRANS_NONSEQ, 1, 1, 0, 32'h0, HSIZE_WORD, 0, 0, 1, 32'h0);
        add("r_wrap",    0, HTRANS_NONSEQ, 1, 1, 0, 32'hFFFF_FFFC, HSIZE_WORD, 0, 1, 1, 32'h0);
        add("w3f_byte",  0, HTRANS_SEQ,    1, 1, 1, 32'h3F, HSIZE_BYTE, 32'h7E00_0000, 0, 0, 0);
        add("r3c_last",  0, HTRANS_NONSEQ, 1, 1, 0, 32'h3C, HSIZE_WORD, 0, 0, 1, 32'h7E00_0000);
        add("r7_byte",   0, HTRANS_NONSEQ, 1, 1, 0, 32'h7, HSIZE_BYTE, 0, 0, 1, 32'h5566_AA44);
        add("w10_ws3",   2, HTRANS_NONSEQ, 1, 1, 1, 32'h10, HSIZE_WORD, 32'h0BAD_F00D, 0, 0, 0);
        add("r10_ws3",   2, HTRANS_NONSEQ, 1, 1, 0, 32'h10, HSIZE_WORD, 0, 0, 1, 32'h0BAD_F00D);
        add("busy_ws3",  2, HTRANS_BUSY,   1, 1, 0, 32'h14, HSIZE_WORD, 0, 0, 1, 32'h0BAD_F00D);
        add("idle_ws3",  2, HTRANS_IDLE,   1, 1, 0, 32'h14, HSIZE_WORD, 0, 0, 1, 32'h0BAD_F00D);
        add("r2_ws3",    2, HTRANS_NONSEQ, 1, 1, 0, 32'h2, HSIZE_WORD, 0, 1, 1, 32'h0BAD_F00D);
        add("r14_ws3",   2, HTRANS_NONSEQ, 1, 1, 0, 32'h14, HSIZE_WORD, 0, 0, 1, 32'h0);
        run_vecs();

        // Back-to-back write then read of the same word with no wait states.
        cur    = 0;
        hsel   = 3'b001;
        htrans = HTRANS_NONSEQ;
        hwrite = 1'b1;
        haddr  = 32'h4;
        hsize  = HSIZE_WORD;
        cyc();
        hwdata = 32'hDEAD_BEEF;
        hwrite = 1'b0;
        @(negedge clk);
        chk("pipe_wr hreadyout", 32'(rdy[0]), 32'd1);
        cyc();
        hsel   = '0;
        htrans = HTRANS_IDLE;
        @(negedge clk);
        chk("pipe_rd hreadyout", 32'(rdy[0]), 32'd1);
        chk("pipe_rd hresp", 32'(rsp[0]), 32'd0);
        chk("pipe_rd hrdata", rdat[0], 32'hDEAD_BEEF);
        cyc();
        add("r4_after_pipe", 0, HTRANS_NONSEQ, 1, 1, 0, 32'h4, HSIZE_WORD, 0, 0, 1, 32'hDEAD_BEEF);
        add("w8_ws2",        1, HTRANS_NONSEQ, 1, 1, 1, 32'h8, HSIZE_WORD, 32'h1234_5678, 0, 0, 0);
        add("r8_ws2",        1, HTRANS_NONSEQ, 1, 1, 0, 32'h8, HSIZE_WORD, 0, 0, 1, 32'h1234_5678);
        run_vecs();

        // Reset while a write sits in its wait states.
        cur    = 1;
        hsel   = 3'b010;
        htrans = HTRANS_NONSEQ;
        hwrite = 1'b1;
        haddr  = 32'hC;
        hsize  = HSIZE_WORD;
        cyc();
        hsel   = '0;
        htrans = HTRANS_IDLE;
        hwdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rst_pre hreadyout", 32'(rdy[1]), 32'd0);
        #1 rst[1] = 1'b1;
        #1;
        chk("rst_mid hreadyout", 32'(rdy[1]), 32'd1);
        chk("rst_mid hresp", 32'(rsp[1]), 32'd0);
        chk("rst_mid hrdata", rdat[1], 32'd0);
        cyc();
        rst[1] = 1'b0;
        cyc();
        add("rc_after_rst", 1, HTRANS_NONSEQ, 1, 1, 0, 32'hC, HSIZE_WORD, 0, 0, 1, 32'h0);
        add("r8_after_rst", 1, HTRANS_NONSEQ, 1, 1, 0, 32'h8, HSIZE_WORD, 0, 0, 1, 32'h0);
        run_vecs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
